// File: rtl/fir_mac_sequencer.sv
// FIR multiply-accumulate sequencer.
// Walks an external combinational saturating-MAC ALU through TAPS steps per
// accepted sample. This block holds the sample delay line, the coefficient
// registers, the running accumulator and the in/out handshakes.

`ifndef ALU_NOP
`define ALU_NOP 8'h00
`endif
`ifndef ALU_MAC
`define ALU_MAC 8'h01
`endif

module fir_mac_sequencer #(
    parameter int N    = 16,
    parameter int TAPS = 8,
    parameter int AW   = 3,
    parameter int O    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [N-1:0]  out_data,
    input  logic          out_ready,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [N-1:0]  coef_data,
    output logic          busy,
    output logic [O-1:0]  alu_opcode,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic [N-1:0]  alu_c,
    input  logic [N-1:0]  alu_out
);

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  x_q    [TAPS];
    logic [N-1:0]  coef_q [TAPS];
    logic [N-1:0]  acc_q;
    logic [N-1:0]  out_data_q;
    logic [AW-1:0] idx_q;

    logic take_sample;
    logic coef_write;
    logic last_tap;

    // A sample in the same IDLE cycle beats a coefficient write; the write is dropped.
    assign take_sample = (state_q == StIdle) && in_valid;
    assign coef_write  = (state_q == StIdle) && !in_valid && coef_we &&
                         (32'(coef_addr) < 32'(TAPS));
    assign last_tap    = (idx_q == AW'(TAPS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> MAC (TAPS cycles) -> OUT -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StMac;
            StMac:   if (last_tap) state_d = StOut;
            StOut:   if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath: delay line shift, tap index, running accumulator and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
            end
            acc_q      <= '0;
            idx_q      <= '0;
            out_data_q <= '0;
        end else begin
            if (take_sample) begin
                for (int k = TAPS - 1; k > 0; k--) begin
                    x_q[k] <= x_q[k-1];
                end
                x_q[0] <= in_data;
                acc_q  <= '0;
                idx_q  <= '0;
            end else if (state_q == StMac) begin
                // The ALU already clamps each partial sum, so acc stays N bits wide.
                acc_q <= alu_out;
                idx_q <= last_tap ? '0 : idx_q + AW'(1);
                if (last_tap) begin
                    out_data_q <= alu_out;
                end
            end
        end
    end

    // Coefficient register file, writable only from an idle, sample-free cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                coef_q[k] <= '0;
            end
        end else if (coef_write) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    // Output decode: handshakes, busy and ALU drive from the current state.
    always_comb begin
        in_ready   = 1'b0;
        busy       = 1'b1;
        out_valid  = 1'b0;
        alu_opcode = O'(`ALU_NOP);
        alu_a      = '0;
        alu_b      = '0;
        alu_c      = '0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            StMac: begin
                alu_opcode = O'(`ALU_MAC);
                alu_a      = x_q[idx_q];
                alu_b      = coef_q[idx_q];
                alu_c      = acc_q;
            end
            StOut: begin
                out_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign out_data = out_data_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: directed cases plus random traffic, checked
// against a direct FIR evaluation with per-step saturation.

`ifndef ALU_NOP
`define ALU_NOP 8'h00
`endif
`ifndef ALU_MAC
`define ALU_MAC 8'h01
`endif

module tb_fir_mac_sequencer;

    localparam int N    = 16;
    localparam int TAPS = 4;
    localparam int AW   = 2;
    localparam int O    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [N-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [N-1:0]  out_data;
    logic          out_ready;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [N-1:0]  coef_data;
    logic          busy;
    logic [O-1:0]  alu_opcode;
    logic [N-1:0]  alu_a;
    logic [N-1:0]  alu_b;
    logic [N-1:0]  alu_c;
    logic [N-1:0]  alu_out;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: coefficients and the sample history, newest first.
    logic signed [N-1:0] m_coef [TAPS];
    logic signed [N-1:0] m_x    [TAPS];

    always #5 clk = ~clk;

    fir_mac_sequencer #(.N(N), .TAPS(TAPS), .AW(AW), .O(O)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy),
        .alu_opcode(alu_opcode),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c     (alu_c),
        .alu_out   (alu_out)
    );

    function automatic logic [N-1:0] sat16(input longint v);
        logic [63:0] t;
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        t = v;
        return t[15:0];
    endfunction

    // External ALU: saturating a*b+c on MAC, zero otherwise.
    always_comb begin
        alu_out = '0;
        if (alu_opcode == O'(`ALU_MAC)) begin
            alu_out = sat16(longint'($signed(alu_a)) * longint'($signed(alu_b)) +
                            longint'($signed(alu_c)));
        end
    end

    function automatic logic [N-1:0] model_out();
        longint acc;
        acc = 0;
        for (int i = 0; i < TAPS; i++) begin
            acc = longint'($signed(sat16(acc + longint'(m_x[i]) * longint'(m_coef[i]))));
        end
        return sat16(acc);
    endfunction

    task automatic check_eq(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check_eq("wait_in_ready", N'(in_ready), N'(1));
    endtask

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin
            m_coef[k] = '0;
            m_x[k]    = '0;
        end
    endtask

    task automatic write_coef(input logic [AW-1:0] a, input logic [N-1:0] d);
        wait_ready();
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        tick();
        coef_we = 1'b0;
        m_coef[a] = d;
    endtask

    // One sample through the filter; poke drives coef_we alongside the sample
    // and throughout MAC, all of which the DUT must ignore.
    task automatic run_sample(input logic [N-1:0] s, input int hold, input bit poke);
        int n;
        logic [N-1:0] exp;
        logic [N-1:0] held;
        wait_ready();
        in_valid = 1'b1;
        in_data  = s;
        if (poke) begin
            coef_we   = 1'b1;
            coef_addr = AW'($urandom_range(0, TAPS - 1));
            coef_data = 16'h1234;
        end
        tick();
        in_valid = 1'b0;
        for (int k = TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
        m_x[0] = s;
        exp = model_out();
        check_eq("mac_busy", N'(busy), N'(1));
        check_eq("mac_in_ready", N'(in_ready), N'(0));
        check_eq("mac_opcode", N'(alu_opcode), N'(`ALU_MAC));
        check_eq("mac_alu_a0", alu_a, s);
        check_eq("mac_alu_c0", alu_c, '0);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        coef_we = 1'b0;
        check_eq("latency", N'(n), N'(TAPS));
        check_eq("out_data", out_data, exp);
        check_eq("out_opcode", N'(alu_opcode), N'(`ALU_NOP));
        held = out_data;
        for (int c = 0; c < hold; c++) begin
            tick();
            check_eq("hold_valid", N'(out_valid), N'(1));
            check_eq("hold_data", out_data, held);
            check_eq("hold_in_ready", N'(in_ready), N'(0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("post_valid", N'(out_valid), N'(0));
        check_eq("post_in_ready", N'(in_ready), N'(1));
        check_eq("post_data", out_data, held);
    endtask

    task automatic impulse();
        run_sample(16'd1, 0, 1'b0);
        for (int k = 1; k < TAPS; k++) run_sample(16'd0, 0, 1'b0);
    endtask

    task automatic check_idle_reset_state();
        check_eq("rst_in_ready", N'(in_ready), N'(1));
        check_eq("rst_busy", N'(busy), N'(0));
        check_eq("rst_out_valid", N'(out_valid), N'(0));
        check_eq("rst_out_data", out_data, '0);
        check_eq("rst_opcode", N'(alu_opcode), N'(`ALU_NOP));
        check_eq("rst_alu_a", alu_a, '0);
        check_eq("rst_alu_b", alu_b, '0);
        check_eq("rst_alu_c", alu_c, '0);
    endtask

    initial begin
        logic [15:0] t1 [4];
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        check_idle_reset_state();

        // Basic ramp with coef {1,2,3,4}.
        t1[0] = 16'd1; t1[1] = 16'd2; t1[2] = 16'd3; t1[3] = 16'd4;
        for (int k = 0; k < TAPS; k++) write_coef(AW'(k), t1[k]);
        run_sample(16'd10, 0, 1'b0);
        run_sample(16'd20, 0, 1'b0);
        run_sample(16'd30, 0, 1'b0);
        run_sample(16'd40, 0, 1'b0);

        // Saturation at both rails.
        for (int k = 0; k < TAPS; k++) write_coef(AW'(k), 16'h7FFF);
        for (int k = 0; k < TAPS; k++) run_sample(16'h7FFF, 0, 1'b0);
        for (int k = 0; k < TAPS; k++) run_sample(16'h8000, 0, 1'b0);

        // Per-step clamp: sum saturates at tap 0 and must stay there.
        t1[0] = 16'h7FFF; t1[1] = 16'd1; t1[2] = 16'd0; t1[3] = 16'd0;
        for (int k = 0; k < TAPS; k++) write_coef(AW'(k), t1[k]);
        for (int k = 0; k < TAPS; k++) run_sample(16'd0, 0, 1'b0);
        run_sample(16'd1000, 0, 1'b0);
        run_sample(16'h7FFF, 0, 1'b0);
        // Negative partial then positive: final-only clamp would differ.
        run_sample(16'h8000, 0, 1'b0);

        // Backpressure.
        run_sample(16'h0123, 10, 1'b0);

        // Writes during MAC and alongside a sample are dropped; impulse reads back.
        t1[0] = 16'd7; t1[1] = 16'hFFFD; t1[2] = 16'd11; t1[3] = 16'h0100;
        for (int k = 0; k < TAPS; k++) write_coef(AW'(k), t1[k]);
        run_sample(16'd55, 0, 1'b1);
        run_sample(16'hFF00, 2, 1'b1);
        impulse();

        // Reset in the middle of MAC at tap 2.
        wait_ready();
        in_valid = 1'b1;
        in_data  = 16'd5;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check_idle_reset_state();
        impulse();

        // Random traffic.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                write_coef(AW'($urandom_range(0, TAPS - 1)),
                           ($urandom_range(0, 3) == 0) ? 16'h7FFF : N'($urandom));
            end
            run_sample(($urandom_range(0, 4) == 0) ? 16'h8000 : N'($urandom),
                       int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
